stack_control_unit: RTL

- Instruction sequencer that generates the control word for the register-stack/ALU datapath: stackOP, aluOP, mux_selector and immediate.
- Fetches 16-bit instruction words from instruction memory over a req/ack handshake and decodes them.
- Drives each datapath operation for exactly one clock.
- Reads top-of-stack back from the datapath to resolve conditional jumps.

---
 rtl/stack_control_unit_if.sv | 25 ++
 rtl/stack_control_unit.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/stack_control_unit_if.sv
// Instruction-memory fetch bus between the stack control unit and program memory.
// The controller (master) holds imem_req/imem_addr stable until the slave answers
// with imem_ack, which qualifies imem_rdata in that same cycle.
interface stack_control_unit_if #(
    parameter int ADDR_W = 12
);
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_req;
    logic              imem_ack;
    logic [15:0]       imem_rdata;

    modport master (
        output imem_addr,
        output imem_req,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_addr,
        input  imem_req,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/stack_control_unit.sv
// Instruction sequencer for the register-stack/ALU datapath. Fetches 16-bit
// words over the imem bus, decodes them and presents a registered control word
// (stackOP/aluOP/mux_selector/immediate) for exactly one EXEC cycle per
// instruction. Top-of-stack is read back to resolve JZ.
module stack_control_unit #(
    parameter int                ADDR_W   = 12,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                        CLK,
    input  logic                        reset,
    input  logic                        run,
    stack_control_unit_if.master        imem,
    input  logic [15:0]                 tos_a,
    output logic [2:0]                  stackOP,
    output logic [3:0]                  aluOP,
    output logic [2:0]                  mux_selector,
    output logic [15:0]                 immediate,
    output logic                        halted,
    output logic                        illegal
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_FETCH_IMM,
        S_EXEC,
        S_HALT
    } state_t;

    typedef enum logic [3:0] {
        OP_NOP   = 4'h0,
        OP_PUSHI = 4'h1,
        OP_PUSHS = 4'h2,
        OP_POP   = 4'h3,
        OP_ALU   = 4'h4,
        OP_DUP   = 4'h5,
        OP_SWAP  = 4'h6,
        OP_JMP   = 4'h7,
        OP_JZ    = 4'h8,
        OP_HALT  = 4'hF
    } opcode_t;

    typedef enum logic [2:0] {
        SOP_HOLD      = 3'd0,
        SOP_PUSH      = 3'd1,
        SOP_POP       = 3'd2,
        SOP_POP2_PUSH = 3'd3,
        SOP_SWAP      = 3'd4,
        SOP_DUP       = 3'd5
    } stack_op_t;

    localparam logic [2:0] MUX_ALU = 3'd0;
    localparam logic [2:0] MUX_IMM = 3'd1;

    typedef struct packed {
        logic [2:0]  stack_op;
        logic [3:0]  alu_op;
        logic [2:0]  mux_sel;
        logic [15:0] imm;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '0;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [15:0]       instr_q, instr_d;
    ctrl_t             ctrl_q, ctrl_d;
    logic              illegal_q, illegal_d;

    logic [3:0]        exec_opcode;
    logic [ADDR_W-1:0] jump_target;

    assign exec_opcode = instr_q[15:12];
    assign jump_target = ADDR_W'(instr_q[11:0]);

    // Next-state, PC, instruction latch and next control word.
    // NOTE: every signal written here gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        ctrl_d    = CTRL_IDLE;
        illegal_d = illegal_q;

        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
            end

            S_FETCH: begin
                if (imem.imem_ack) begin
                    instr_d = imem.imem_rdata;
                    pc_d    = pc_q + ADDR_W'(1);
                    state_d = S_EXEC;
                    case (imem.imem_rdata[15:12])
                        OP_PUSHI: state_d = S_FETCH_IMM;
                        OP_PUSHS: begin
                            ctrl_d.stack_op = SOP_PUSH;
                            ctrl_d.mux_sel  = MUX_IMM;
                            ctrl_d.imm      = {{4{imem.imem_rdata[11]}}, imem.imem_rdata[11:0]};
                        end
                        OP_POP:  ctrl_d.stack_op = SOP_POP;
                        OP_ALU: begin
                            ctrl_d.stack_op = SOP_POP2_PUSH;
                            ctrl_d.alu_op   = imem.imem_rdata[3:0];
                            ctrl_d.mux_sel  = MUX_ALU;
                        end
                        OP_DUP:  ctrl_d.stack_op = SOP_DUP;
                        OP_SWAP: ctrl_d.stack_op = SOP_SWAP;
                        OP_NOP, OP_JMP, OP_JZ, OP_HALT: ctrl_d.stack_op = SOP_HOLD;
                        default: begin
                            // Opcodes 9-E are undefined: stop without touching the stack.
                            state_d   = S_HALT;
                            illegal_d = 1'b1;
                        end
                    endcase
                end
            end

            S_FETCH_IMM: begin
                if (imem.imem_ack) begin
                    pc_d            = pc_q + ADDR_W'(1);
                    ctrl_d.stack_op = SOP_PUSH;
                    ctrl_d.mux_sel  = MUX_IMM;
                    ctrl_d.imm      = imem.imem_rdata;
                    state_d         = S_EXEC;
                end
            end

            S_EXEC: begin
                state_d = S_FETCH;
                case (exec_opcode)
                    OP_HALT: state_d = S_HALT;
                    OP_JMP:  pc_d    = jump_target;
                    OP_JZ:   if (tos_a == 16'h0000) pc_d = jump_target;
                    default: ;
                endcase
            end

            S_HALT: ;

            default: state_d = S_IDLE;
        endcase
    end

    // State, PC, instruction and control-word registers.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values computed above. All registers, including the
    // instruction latch, are reset so a reset mid-fetch leaves nothing stale.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC;
            instr_q   <= '0;
            ctrl_q    <= CTRL_IDLE;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            ctrl_q    <= ctrl_d;
            illegal_q <= illegal_d;
        end
    end

    assign imem.imem_req  = (state_q == S_FETCH) || (state_q == S_FETCH_IMM);
    assign imem.imem_addr = pc_q;

    assign stackOP      = ctrl_q.stack_op;
    assign aluOP        = ctrl_q.alu_op;
    assign mux_selector = ctrl_q.mux_sel;
    assign immediate    = ctrl_q.imm;
    assign halted       = (state_q == S_HALT);
    assign illegal      = illegal_q;

endmodule
